// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the RV64 data memory.
// Holds the load/store funct3 encodings, the access-size decoder and the
// default array depth used by data_memory and dmem_lane_align.
package dmem_pkg;

  // Default number of 64-bit doublewords in the array.
  localparam int DMEM_DEPTH_DEFAULT = 256;

  // RISC-V load/store funct3 encodings.
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_D    = 3'b011;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;
  localparam logic [2:0] F3_WU   = 3'b110;
  localparam logic [2:0] F3_RSVD = 3'b111;

  // Access size in bytes (1/2/4/8), taken from the low two funct3 bits.
  function automatic logic [3:0] f3_size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory.
// Store path: builds the byte mask for the addressed lanes and merges the
// low bytes of the store data into the current word.
// Load path: shifts the addressed lane down and sign/zero-extends it.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [2:0]  offset_i,
  input  logic [63:0] word_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] merged_o,
  output logic [63:0] load_o
);

  logic [7:0]  lane_mask;
  logic [7:0]  byte_mask;
  logic [63:0] bit_mask;
  logic [63:0] wdata_shifted;
  logic [63:0] lane;

  // Store merge: replace only the addressed bytes, keep the rest of the word.
  // NOTE: every signal assigned in an always_comb gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lane_mask     = 8'((9'd1 << f3_size_bytes(funct3_i)) - 9'd1);
    byte_mask     = lane_mask << offset_i;
    bit_mask      = '0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{byte_mask[i]}};
    end
    wdata_shifted = wdata_i << {offset_i, 3'b000};
    merged_o      = (word_i & ~bit_mask) | (wdata_shifted & bit_mask);
  end

  // Load extract: bring the addressed lane to bit 0 and extend it.
  always_comb begin
    lane   = word_i >> {offset_i, 3'b000};
    load_o = '0;
    case (funct3_i)
      F3_B:    load_o = {{56{lane[7]}},  lane[7:0]};
      F3_H:    load_o = {{48{lane[15]}}, lane[15:0]};
      F3_W:    load_o = {{32{lane[31]}}, lane[31:0]};
      F3_D:    load_o = lane;
      F3_BU:   load_o = {56'd0, lane[7:0]};
      F3_HU:   load_o = {48'd0, lane[15:0]};
      F3_WU:   load_o = {32'd0, lane[31:0]};
      default: load_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Load/store data memory for the single-cycle RV64 datapath.
// Combinational read, single-edge byte-masked store, access checking and a
// sticky first-fault latch. Optional access counters are enabled with the
// DMEM_ACCESS_CNT_EN macro; without it Load_Count/Store_Count read 0.
module data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEFAULT,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] Address,
  input  logic [63:0] Write_Data,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  input  logic [2:0]  Funct3,
  input  logic        Fault_Clear,
  output logic [63:0] Read_Data,
  output logic        Access_Fault,
  output logic        Fault_Flag,
  output logic [63:0] Fault_Addr,
  output logic [31:0] Load_Count,
  output logic [31:0] Store_Count
);

  logic [63:0]      mem_q [DEPTH];
  logic [IDX_W-1:0] idx;
  logic [2:0]       offset;
  logic             out_of_range;
  logic             misaligned;
  logic             fault_cause;
  logic             good_load;
  logic             good_store;
  logic [63:0]      cur_word;
  logic [63:0]      merged_word;
  logic [63:0]      load_word;

  logic             fault_flag_q, fault_flag_d;
  logic [63:0]      fault_addr_q, fault_addr_d;

  // Access decode and fault classification; everything is gated off in reset.
  always_comb begin
    idx          = Address[IDX_W+2:3];
    offset       = Address[2:0];
    out_of_range = |Address[63:IDX_W+3];
    misaligned   = |(offset & 3'(f3_size_bytes(Funct3) - 4'd1));
    fault_cause  = (Funct3 == F3_RSVD) | misaligned | out_of_range
                 | (Mem_Read & Mem_Write) | (Mem_Write & Funct3[2]);
    Access_Fault = ~rst & (Mem_Read | Mem_Write) & fault_cause;
    good_load    = ~rst & Mem_Read  & ~Access_Fault;
    good_store   = ~rst & Mem_Write & ~Access_Fault;
    cur_word     = mem_q[idx];
    Read_Data    = good_load ? load_word : '0;
  end

  dmem_lane_align u_lane_align (
    .funct3_i (Funct3),
    .offset_i (offset),
    .word_i   (cur_word),
    .wdata_i  (Write_Data),
    .merged_o (merged_word),
    .load_o   (load_word)
  );

  // Array: cleared by reset, otherwise a masked store on a non-faulting write.
  // NOTE: the array is cleared on reset because software relies on zeroed memory, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (good_store) begin
      // NOTE: sequential state is written with <= so every flop samples pre-edge values regardless of statement order.
      mem_q[idx] <= merged_word;
    end
  end

  // Fault latch next state: a new fault beats a clear, first fault address wins.
  always_comb begin
    fault_flag_d = fault_flag_q;
    fault_addr_d = fault_addr_q;
    if (Access_Fault) begin
      fault_flag_d = 1'b1;
      if (!fault_flag_q || Fault_Clear) begin
        fault_addr_d = Address;
      end
    end else if (Fault_Clear) begin
      fault_flag_d = 1'b0;
      fault_addr_d = '0;
    end
  end

  // Fault latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_flag_q <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_flag_q <= fault_flag_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign Fault_Flag = fault_flag_q;
  assign Fault_Addr = fault_addr_q;

`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] load_cnt_q,  load_cnt_d;
  logic [31:0] store_cnt_q, store_cnt_d;

  // Counter next state: a clear restarts from 0 but still counts this access.
  always_comb begin
    load_cnt_d  = (Fault_Clear ? 32'd0 : load_cnt_q)  + 32'(good_load);
    store_cnt_d = (Fault_Clear ? 32'd0 : store_cnt_q) + 32'(good_store);
  end

  // Access counters, wrapping naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign Load_Count  = load_cnt_q;
  assign Store_Count = store_cnt_q;
`else
  assign Load_Count  = '0;
  assign Store_Count = '0;
`endif

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
Load/store data memory directly downstream of the 64-bit ALU in the single-cycle RV64 datapath. The ALU sum output is the byte address, and rs2 is the store data. Read is combinational so loads complete in the same cycle. Store is a single clock edge. The block also detects misaligned, out-of-range and illegal accesses and latches the first fault for the core and debug.

Parameters:
DEPTH, 256, number of 64-bit doublewords; power of two, minimum 2.
IDX_W, $clog2(DEPTH), doubleword index width (derived; do not override).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
Address  in  64  byte address (ALU sum).
Write_Data  in  64  store data (rs2).
Mem_Read  in  1  load strobe.
Mem_Write  in  1  store strobe.
Funct3  in  3  RISC-V load/store funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
Fault_Clear  in  1  clears sticky fault state.
Read_Data  out  64  extended load result.
Access_Fault  out  1  combinational fault indication for the current access.
Fault_Flag  out  1  sticky fault flag.
Fault_Addr  out  64  address of the first fault since the last clear.
Load_Count  out  32  successful loads (optional feature).
Store_Count  out  32  successful stores (optional feature).

Behaviour:
- Only clk is used. All state updates on the rising edge. rst is sampled synchronously and has priority over everything else.
- Reset state: every array word = 0; Fault_Flag = 0; Fault_Addr = 0; counters = 0.
  - While rst is high, Read_Data = 0, Access_Fault = 0, and no write occurs.
- Addressing:
  - Index = Address[IDX_W+2:3]; byte offset = Address[2:0].
  - Access size = 1/2/4/8 bytes, taken from Funct3[1:0].
- Access_Fault is asserted when (Mem_Read | Mem_Write) and any of:
  - Funct3 = 111.
  - Misaligned: offset is not a multiple of the size.
  - Out of range: Address[63:IDX_W+3] != 0.
  - Mem_Read and Mem_Write both high.
  - Store with Funct3[2] = 1.
- Load (Mem_Read, no fault):
  - Read_Data is combinational, zero added latency.
  - The selected lane is sign-extended for B/H/W and zero-extended for BU/HU/WU/D.
- Read_Data = 0 in all of these cases: no Mem_Read, faulting access, Mem_Write high.
- Store (Mem_Write, no fault):
  - At the clock edge, only the addressed byte lanes of the word are updated from the low bytes of Write_Data.
  - Other bytes are preserved.
- A faulting store never modifies the array.
- Read-during-write at the same address: Read_Data shows pre-edge contents; new data is visible after the edge.
- Fault latch:
  - On an edge with Access_Fault = 1: Fault_Flag is set to 1.
  - Fault_Addr captures Address only if Fault_Flag was 0, so the first fault wins.
  - Fault_Clear = 1 alone: Fault_Flag = 0 and Fault_Addr = 0 at the edge.
  - Fault_Clear together with a new fault: the new fault wins; Fault_Flag = 1 and Fault_Addr = the new Address.
- No FSM. Sequential state consists of the array, the fault latch and the counters.

Optional Feature:
Macro DMEM_ACCESS_CNT_EN.
- Defined:
  - Load_Count increments on each edge with a non-faulting load.
  - Store_Count increments on each edge with a non-faulting store.
  - Both are 32-bit and wrap FFFF_FFFF -> 0.
  - Both clear on rst and on Fault_Clear; a clear and a count in the same cycle gives 1.
- Not defined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package dmem_pkg holds:
  - Funct3 constants: F3_B/H/W/D/BU/HU/WU.
  - Size-decode function funct3 -> byte count.
  - Default DEPTH constant.
- One combinational sub-module, dmem_lane_align, which does two things:
  - Builds the store byte mask and merged write word.
  - Extracts and extends the load lane.
- The top level holds the array, fault latch and counters.

Test Plan:
- Store/load each width: SD 0x8899AABBCCDDEEFF @0x10; then LB @0x10 -> 0xFFFFFFFFFFFFFFFF, LBU @0x10 -> 0xFF, LH @0x12 -> 0xFFFFFFFFFFFFCCDD, LWU @0x14 -> 0x8899AABB, LD @0x10 -> full value.
- Partial store: SD 0 @0x20, SB 0x5A @0x23 -> LD @0x20 = 0x000000005A000000.
- Misaligned: SW @0x22 -> Access_Fault = 1, word @0x20 unchanged, Fault_Flag = 1, Fault_Addr = 0x22; then LH @0x21 -> Fault_Addr stays 0x22.
- Out of range and illegal, DEPTH = 256:
  - LD @0x800 -> fault, Read_Data = 0.
  - Funct3 = 111 load -> fault.
  - Mem_Read = Mem_Write = 1 -> fault, no write.
- Clear/reset races:
  - Fault_Clear together with a fault @0x41 -> Fault_Addr = 0x41.
  - rst mid-sequence -> all words read 0, flags and counters 0.
- Counters (macro on): 3 good loads, 2 good stores, 1 faulting load -> Load_Count = 3, Store_Count = 2.
  - Preload the counter to FFFF_FFFF via force, then one good load -> wraps to 0.
